// File: rtl/adder_chk_pkg.sv
// ============================================================================
// Module : adder_chk_pkg
// Brief  : Shared types and width helpers for the exhaustive adder checker.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package adder_chk_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRIVE = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  localparam int DEFAULT_WIDTH = 4;
  localparam int DRAIN_W       = 3;

  // Vector index covers {cin, b, a}; the error counter needs one more bit.
  function automatic int vec_w(input int width);
    return 2 * width + 1;
  endfunction

  function automatic int cnt_w(input int width);
    return 2 * width + 2;
  endfunction

  function automatic longint num_vec(input int width);
    return longint'(1) << vec_w(width);
  endfunction

  localparam int NUM_VEC = 1 << vec_w(DEFAULT_WIDTH);

endpackage

`default_nettype wire

// File: rtl/adder_chk_delay.sv
// ============================================================================
// Module : adder_chk_delay
// Brief  : DEPTH-stage register delay line; DEPTH=0 degenerates to a wire.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module adder_chk_delay #(
  parameter int DEPTH = 0,
  parameter int DW    = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] data_i,
  output logic [DW-1:0] data_o
);

  generate
    if (DEPTH == 0) begin : g_wire
      logic unused_clk_rst;
      assign unused_clk_rst = clk ^ rst_n;
      assign data_o = data_i;
    end else begin : g_pipe
      logic [DW-1:0] stage_q [DEPTH];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
        end else begin
          stage_q[0] <= data_i;
          for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
        end
      end

      assign data_o = stage_q[DEPTH-1];
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/adder_sweep_checker.sv
// ============================================================================
// Module : adder_sweep_checker
// Brief  : Drives every {cin,b,a} vector into an external adder and checks
//          the returned sum. First-fail capture built only when the macro
//          ADDER_CHK_FIRST_FAIL_EN is defined.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module adder_sweep_checker
  import adder_chk_pkg::*;
#(
  parameter int WIDTH       = 4,
  parameter int DUT_LATENCY = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  output logic [WIDTH-1:0]     op_a,
  output logic [WIDTH-1:0]     op_b,
  output logic                 op_cin,
  input  logic [WIDTH:0]       dut_sum,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [2*WIDTH+1:0]   err_count,
  output logic [2*WIDTH:0]     fail_vec,
  output logic [WIDTH:0]       fail_sum
);

  localparam int VW = vec_w(WIDTH);
  localparam int CW = cnt_w(WIDTH);
  localparam int SW = WIDTH + 1;
  localparam int PW = 1 + VW + SW;

  // Async assert, two-flop synchronised release.
  logic [1:0] rst_sync_q;
  logic       rst_int_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync_q <= '0;
    else        rst_sync_q <= {rst_sync_q[0], 1'b1};
  end

  assign rst_int_n = rst_sync_q[1];

  state_e             state_q, state_d;
  logic [VW-1:0]      vec_q, vec_d;
  logic [DRAIN_W-1:0] drain_q, drain_d;
  logic [CW-1:0]      err_q, err_d;

  logic [SW-1:0] golden;
  logic [PW-1:0] pipe_in, pipe_out;
  logic          chk_valid;
  logic [VW-1:0] chk_vec;
  logic [SW-1:0] chk_sum;
  logic          mismatch;
  logic          start_acc;

  assign golden = SW'(vec_q[WIDTH-1:0]) + SW'(vec_q[2*WIDTH-1:WIDTH]) + SW'(vec_q[2*WIDTH]);
  assign pipe_in = {state_q == S_DRIVE, vec_q, golden};

  adder_chk_delay #(
    .DEPTH (DUT_LATENCY),
    .DW    (PW)
  ) u_exp_dly (
    .clk    (clk),
    .rst_n  (rst_int_n),
    .data_i (pipe_in),
    .data_o (pipe_out)
  );

  assign chk_valid = pipe_out[PW-1];
  assign chk_vec   = pipe_out[SW +: VW];
  assign chk_sum   = pipe_out[SW-1:0];
  assign mismatch  = chk_valid && (dut_sum != chk_sum);
  assign start_acc = start && ((state_q == S_IDLE) || (state_q == S_DONE));

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    drain_d = drain_q;
    err_d   = err_q;
    if (mismatch) err_d = err_q + CW'(1);
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_DRIVE;
          vec_d   = '0;
          err_d   = '0;
        end
      end
      S_DRIVE: begin
        if (&vec_q) begin
          drain_d = '0;
          state_d = (DUT_LATENCY == 0) ? S_DONE : S_DRAIN;
        end else begin
          vec_d = vec_q + VW'(1);
        end
      end
      S_DRAIN: begin
        if (drain_q == DRAIN_W'(DUT_LATENCY - 1)) state_d = S_DONE;
        else                                      drain_d = drain_q + DRAIN_W'(1);
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state_q <= S_IDLE;
      vec_q   <= '0;
      drain_q <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      drain_q <= drain_d;
      err_q   <= err_d;
    end
  end

`ifdef ADDER_CHK_FIRST_FAIL_EN
  logic [VW-1:0] fail_vec_q;
  logic [SW-1:0] fail_sum_q;

  // A zero error count before this check marks the first failure of the sweep.
  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      fail_vec_q <= '0;
      fail_sum_q <= '0;
    end else if (start_acc) begin
      fail_vec_q <= '0;
      fail_sum_q <= '0;
    end else if (mismatch && (err_q == '0)) begin
      fail_vec_q <= chk_vec;
      fail_sum_q <= dut_sum;
    end
  end

  assign fail_vec = fail_vec_q;
  assign fail_sum = fail_sum_q;
`else
  logic unused_fail;
  assign unused_fail = ^{chk_vec, start_acc};
  assign fail_vec    = '0;
  assign fail_sum    = '0;
`endif

  assign op_a      = vec_q[WIDTH-1:0];
  assign op_b      = vec_q[2*WIDTH-1:WIDTH];
  assign op_cin    = vec_q[2*WIDTH];
  assign busy      = (state_q == S_DRIVE) || (state_q == S_DRAIN);
  assign done      = (state_q == S_DONE);
  assign pass      = done && (err_q == '0);
  assign err_count = err_q;

endmodule

`default_nettype wire

// File: doc/adder_sweep_checker.md
ADDER_SWEEP_CHECKER -- requirements
Module: adder_sweep_checker

Interface
REQ-001 Parameter WIDTH, default 4, operand width of the adder under test.
REQ-002 Parameter DUT_LATENCY, default 0, clock cycles from operand presentation to valid dut_sum; range 0..7.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 start  input  1  one-cycle pulse requesting an exhaustive sweep.
REQ-006 op_a  output  WIDTH  operand a driven to the adder under test.
REQ-007 op_b  output  WIDTH  operand b driven to the adder under test.
REQ-008 op_cin  output  1  carry-in driven to the adder under test.
REQ-009 dut_sum  input  WIDTH+1  {carry_out, sum} returned by the adder under test.
REQ-010 busy  output  1  high while a sweep or drain is in progress.
REQ-011 done  output  1  high from sweep completion until the next accepted start.
REQ-012 pass  output  1  valid while done; high iff err_count is zero.
REQ-013 err_count  output  2*WIDTH+2  number of mismatching vectors in the current or last sweep.
REQ-014 fail_vec  output  2*WIDTH+1  index of the first mismatching vector.
REQ-015 fail_sum  output  WIDTH+1  dut_sum observed for the first mismatching vector.

Function
REQ-016 The block SHALL implement states IDLE, DRIVE, DRAIN, DONE.
REQ-017 IDLE or DONE with start=1 SHALL go to DRIVE, clearing err_count, fail_vec, fail_sum, the vector counter vec, and done.
REQ-018 start in DRIVE or DRAIN SHALL be ignored.
REQ-019 In DRIVE, vec (2*WIDTH+1 bits) SHALL increment once per cycle from 0; op_a=vec[WIDTH-1:0], op_b=vec[2*WIDTH-1:WIDTH], op_cin=vec[2*WIDTH], all registered.
REQ-020 After vector 2^(2*WIDTH+1)-1 is presented, the next state SHALL be DRAIN, or DONE directly when DUT_LATENCY=0.
REQ-021 DRAIN SHALL last exactly DUT_LATENCY cycles, with operands held at the last vector.
REQ-022 The vector presented in cycle n SHALL be checked by sampling dut_sum at the rising edge ending cycle n+DUT_LATENCY, against the golden value op_a+op_b+op_cin (WIDTH+1 bits, zero-extended), delayed through a DUT_LATENCY-deep expected-value pipeline.
REQ-023 Each mismatch SHALL increment err_count by 1; overflow is impossible by width.
REQ-024 On the first mismatch of a sweep only, fail_vec and fail_sum SHALL capture the vector index and observed dut_sum.
REQ-025 busy=1 exactly in DRIVE and DRAIN; done=1 exactly in DONE.
REQ-026 With WIDTH=4, done SHALL rise 512+DUT_LATENCY cycles after the edge accepting start.
REQ-027 Pipeline slots not carrying a DRIVE vector SHALL never be checked.

Reset
REQ-028 rst_n low SHALL force IDLE and zero op_a, op_b, op_cin, busy, done, pass, err_count, fail_vec, fail_sum, vec, and the expected-value pipeline.
REQ-029 Reset asserted mid-sweep SHALL abort the sweep with no partial result retained.
REQ-030 Reset deassertion SHALL be synchronised internally; first start is accepted no earlier than the second edge after release.

Configuration
REQ-031 Macro ADDER_CHK_FIRST_FAIL_EN defined: fail_vec and fail_sum behave per REQ-024.
REQ-032 Macro ADDER_CHK_FIRST_FAIL_EN undefined: fail_vec and fail_sum are tied to 0, no capture registers are built, and the port list is unchanged.

Structure
REQ-033 Shared package adder_chk_pkg SHALL hold the state encoding, NUM_VEC = 2^(2*WIDTH+1), and the counter widths derived from WIDTH.
REQ-034 The expected-value delay line SHALL be the sub-module adder_chk_delay (parameters DEPTH, DW; DEPTH=0 is a wire).

Verification
REQ-035 Ideal combinational adder model, DUT_LATENCY=0, start pulse -> done after 512 cycles, err_count=0, pass=1.
REQ-036 dut_sum[0] stuck at 0 -> err_count=256, pass=0, fail_vec=1, fail_sum=5'b00000 (macro on).
REQ-037 Ideal adder registered 2 stages, DUT_LATENCY=2 -> done at cycle 514, err_count=0; same DUT with DUT_LATENCY=0 -> err_count>0.
REQ-038 rst_n pulsed low at vector 100 -> all outputs 0 in IDLE; a following start runs a full 512-vector sweep with pass=1.
REQ-039 start re-pulsed at vector 50 -> ignored, done still at cycle 512; start in DONE -> counters cleared, new sweep begins.
REQ-040 Macro undefined, stuck-at fault as REQ-036 -> err_count=256, fail_vec=0, fail_sum=0.
